// File: rtl/arb_resp_router.sv
// Return-path router: remembers which requester each accepted request belongs to and steers
// in-order responses back to it. Define ARB_RESP_ROUTER_CHECK_EN to build the sticky protocol checker.
module arb_resp_router #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         req_grant,
    input  logic                     req_fire,
    output logic                     req_ready,
    input  logic                     resp_valid,
    output logic                     resp_ready,
    input  logic [DATA_W-1:0]        resp_data,
    output logic [WIDTH-1:0]         out_valid,
    input  logic [WIDTH-1:0]         out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] fifo_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [WIDTH:0]   lower_seen;
    logic [WIDTH-1:0] first_hot;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] head_idx;
    logic             not_empty;
    logic             push;
    logic             pop;

    // Lowest-index-first encode, matching the arbiter's precedence; all-zero yields 0.
    assign lower_seen[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_enc
            assign first_hot[gi]      = req_grant[gi] & ~lower_seen[gi];
            assign lower_seen[gi + 1] = lower_seen[gi] | req_grant[gi];
        end
    endgenerate

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (first_hot[i]) begin
                grant_idx = grant_idx | IDX_W'(i);
            end
        end
    end

    // Ready depends on registered occupancy only, so no resp -> req_ready path exists.
    assign req_ready  = (count_reg != CNT_W'(DEPTH));
    assign not_empty  = (count_reg != '0);
    assign head_idx   = fifo_reg[rd_ptr_reg];
    assign resp_ready = not_empty & out_ready[head_idx];
    assign out_data   = resp_data;
    assign outstanding = count_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_route
            assign out_valid[gi] = not_empty & resp_valid & (head_idx == IDX_W'(gi));
        end
    endgenerate

    assign push = req_fire & req_ready;
    assign pop  = resp_valid & resp_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: entries are only read while count marks them live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr_reg] <= grant_idx;
        end
    end

`ifdef ARB_RESP_ROUTER_CHECK_EN
    logic err_reg, err_next;

    always_comb begin
        err_next = err_reg
                 | (req_fire & ~req_ready)
                 | (req_fire & ~$onehot(req_grant))
                 | (resp_valid & ~not_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_resp_router.sv
// Scoreboard bench for arb_resp_router: stimulus queues expected routes/data, a negedge monitor checks them.
module tb_arb_resp_router;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  req_grant;
    logic              req_fire;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [WIDTH-1:0]  out_valid;
    logic [WIDTH-1:0]  out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        outstanding;
    logic              err;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0]  exp_valid_q [$];
    logic [DATA_W-1:0] exp_data_q  [$];

    arb_resp_router #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_grant  (req_grant),
        .req_fire   (req_fire),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .outstanding(outstanding),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Monitor: compares routing every cycle and retires one scoreboard entry per handshake.
    initial begin
        logic [WIDTH-1:0]  ev;
        logic [DATA_W-1:0] ed;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (out_valid != '0) begin
                    if (exp_valid_q.size() == 0) chk("route_unexpected", 64'(out_valid), 64'(0));
                    else                         chk("route_valid", 64'(out_valid), 64'(exp_valid_q[0]));
                end
                if (resp_valid && resp_ready) begin
                    if (exp_valid_q.size() == 0 || exp_data_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL pop_no_entry: got handshake out_valid=%b expected none", out_valid);
                    end else begin
                        ev = exp_valid_q.pop_front();
                        ed = exp_data_q.pop_front();
                        chk("pop_route", 64'(out_valid), 64'(ev));
                        chk("pop_data", out_data, ed);
                        $display("resp out_valid=%b data=%h", out_valid, out_data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [DATA_W-1:0] t1_data [3];
    logic [WIDTH-1:0]  g;

    initial begin
        t1_data[0] = 64'hAAAA_0000_0000_000A;
        t1_data[1] = 64'hBBBB_0000_0000_000B;
        t1_data[2] = 64'hCCCC_0000_0000_000C;
        rst = 1'b1; req_grant = '0; req_fire = 1'b0;
        resp_valid = 1'b0; resp_data = '0; out_ready = '0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_outstanding", 64'(outstanding), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_resp_ready", 64'(resp_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_err", 64'(err), 64'(0));

        // Three pushes, three in-order responses
        out_ready = 4'b1111;
        req_fire = 1'b1;
        req_grant = 4'b0010; exp_valid_q.push_back(4'b0010); tick();
        req_grant = 4'b1000; exp_valid_q.push_back(4'b1000); tick();
        req_grant = 4'b0001; exp_valid_q.push_back(4'b0001); tick();
        req_fire = 1'b0;
        settle();
        chk("t1_outstanding_full", 64'(outstanding), 64'(3));
        for (int k = 0; k < 3; k++) begin
            resp_valid = 1'b1;
            resp_data  = t1_data[k];
            exp_data_q.push_back(t1_data[k]);
            settle();
            chk("t1_outstanding", 64'(outstanding), 64'(3 - k));
            tick();
        end
        resp_valid = 1'b0;
        settle();
        chk("t1_outstanding_end", 64'(outstanding), 64'(0));

        // Fill to DEPTH, overflow fire ignored, no pop bypass on req_ready
        req_fire = 1'b1;
        req_grant = 4'b0100;
        for (int k = 0; k < DEPTH; k++) begin
            exp_valid_q.push_back(4'b0100);
            tick();
        end
        req_grant = 4'b0001;
        settle();
        chk("t2_full_req_ready", 64'(req_ready), 64'(0));
        chk("t2_full_outstanding", 64'(outstanding), 64'(4));
        tick();
        req_fire = 1'b0;
        settle();
        chk("t2_overflow_ignored", 64'(outstanding), 64'(4));
        resp_valid = 1'b1;
        resp_data  = 64'h0000_2222_0000_0001;
        exp_data_q.push_back(resp_data);
        settle();
        chk("t2_no_bypass", 64'(req_ready), 64'(0));
        tick();
        resp_valid = 1'b0;
        settle();
        chk("t2_ready_after_pop", 64'(req_ready), 64'(1));
        chk("t2_outstanding_after_pop", 64'(outstanding), 64'(3));

        // Backpressure from the routed requester holds the response
        out_ready  = 4'b1011;
        resp_valid = 1'b1;
        resp_data  = 64'h0000_3333_0000_0002;
        exp_data_q.push_back(resp_data);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t3_stall_resp_ready", 64'(resp_ready), 64'(0));
            chk("t3_stall_out_valid", 64'(out_valid), 64'(4'b0100));
            chk("t3_stall_outstanding", 64'(outstanding), 64'(3));
            tick();
        end
        out_ready = 4'b1111;
        settle();
        chk("t3_release_resp_ready", 64'(resp_ready), 64'(1));
        tick();
        resp_valid = 1'b0;
        settle();
        chk("t3_outstanding_after", 64'(outstanding), 64'(2));

        // Steady push+pop at occupancy 2 across pointer wrap
        for (int i = 0; i < 10; i++) begin
            g = 4'b0001 << (i % 4);
            req_fire  = 1'b1;
            req_grant = g;
            exp_valid_q.push_back(g);
            resp_valid = 1'b1;
            resp_data  = 64'h4000 + 64'(i);
            exp_data_q.push_back(resp_data);
            settle();
            chk("t4_outstanding", 64'(outstanding), 64'(2));
            tick();
        end
        req_fire = 1'b0;
        for (int k = 0; k < 2; k++) begin
            resp_data = 64'h5000 + 64'(k);
            exp_data_q.push_back(resp_data);
            tick();
        end
        resp_valid = 1'b0;
        settle();
        chk("t4_drained", 64'(outstanding), 64'(0));

        // Empty response held off; non-one-hot grant encodes lowest bit
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("t5_err_cleared", 64'(err), 64'(0));
        resp_valid = 1'b1;
        settle();
        chk("t5_empty_resp_ready", 64'(resp_ready), 64'(0));
        chk("t5_empty_out_valid", 64'(out_valid), 64'(0));
        tick();
        resp_valid = 1'b0;
        settle();
`ifdef ARB_RESP_ROUTER_CHECK_EN
        chk("t5_err_set", 64'(err), 64'(1));
        tick();
        settle();
        chk("t5_err_sticky", 64'(err), 64'(1));
`else
        chk("t5_err_tied", 64'(err), 64'(0));
`endif
        req_fire  = 1'b1;
        req_grant = 4'b0110;
        exp_valid_q.push_back(4'b0010);
        tick();
        req_fire = 1'b0;
        settle();
        chk("t5_multi_grant_push", 64'(outstanding), 64'(1));
`ifdef ARB_RESP_ROUTER_CHECK_EN
        chk("t5_err_multi", 64'(err), 64'(1));
`endif
        resp_valid = 1'b1;
        resp_data  = 64'h0000_5555_0000_0006;
        exp_data_q.push_back(resp_data);
        tick();
        resp_valid = 1'b0;
        settle();
        chk("t5_drained", 64'(outstanding), 64'(0));

        // Reset mid-response drops all tracking
        req_fire = 1'b1;
        req_grant = 4'b0001; tick();
        req_grant = 4'b0010; tick();
        req_grant = 4'b0100; tick();
        req_fire = 1'b0;
        settle();
        chk("t6_pre_outstanding", 64'(outstanding), 64'(3));
        resp_valid = 1'b1;
        resp_data  = 64'h0000_6666_0000_0007;
        rst = 1'b1;
        exp_valid_q.delete();
        exp_data_q.delete();
        tick();
        rst = 1'b0;
        settle();
        chk("t6_outstanding", 64'(outstanding), 64'(0));
        chk("t6_out_valid", 64'(out_valid), 64'(0));
        chk("t6_resp_ready", 64'(resp_ready), 64'(0));
        chk("t6_req_ready", 64'(req_ready), 64'(1));
        chk("t6_err", 64'(err), 64'(0));
        resp_valid = 1'b0;
        tick();

        chk("sb_valid_empty", 64'(exp_valid_q.size()), 64'(0));
        chk("sb_data_empty", 64'(exp_data_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_resp_router.md
Name: arb_resp_router

Overview:
- Return-path companion to the lowest-index-first priority arbiter on the shared memory/bus port.
- On each accepted request, records which requester was granted in an in-order FIFO.
- Steers each returning response (valid/ready/data) back to that requester.
- Sits between the downstream response channel and WIDTH upstream requesters. Responses are strictly in order.

Parameters:
- WIDTH, 4, number of requesters (grant vector width), >=2
- DEPTH, 4, max outstanding requests; power of two, >=2
- DATA_W, 64, response data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_grant  in  WIDTH  one-hot grant vector from the arbiter
- req_fire  in  1  request accepted downstream this cycle (valid & ready)
- req_ready  out  1  tracking slot available; upstream must AND this into the downstream request valid
- resp_valid  in  1  downstream response valid
- resp_ready  out  1  downstream response ready
- resp_data  in  DATA_W  downstream response payload
- out_valid  out  WIDTH  per-requester response valid; at most one bit set
- out_ready  in  WIDTH  per-requester response ready
- out_data  out  DATA_W  response payload, broadcast to all requesters (= resp_data, combinational)
- outstanding  out  $clog2(DEPTH)+1  current FIFO occupancy
- err  out  1  sticky protocol error flag (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge):
  - rd/wr pointers and count cleared; outstanding=0.
  - req_ready=1, resp_ready=0, out_valid=0, err=0.
  - In-flight entries are discarded; reset mid-operation drops all tracking.
- Index encode:
  - idx = position of the lowest set bit of req_grant (same precedence as the arbiter).
  - req_grant all-zero encodes to 0.
- Push:
  - Occurs on posedge when req_fire & req_ready.
  - Writes idx at wr_ptr; wr_ptr increments modulo DEPTH.
  - req_fire while req_ready=0 is ignored (no push).
- Full:
  - req_ready = (count != DEPTH), registered-state only.
  - No same-cycle pop bypass when full, so there is no combinational path resp -> req_ready.
- Head route:
  - When count != 0, head = fifo[rd_ptr].
  - out_valid[head] = resp_valid; every other out_valid bit = 0.
  - resp_ready = out_ready[head].
- Empty:
  - out_valid = 0 and resp_ready = 0 regardless of resp_valid; the response is held off.
- Pop:
  - Occurs on posedge when resp_valid & resp_ready.
  - rd_ptr increments modulo DEPTH.
- Count:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push/pop is legal at any non-full occupancy, including empty->push with no pop.
- Latency:
  - An entry pushed at edge N is routable from cycle N+1. A response can never return in the same cycle as its request.
- Pointer wrap: natural binary wrap; count disambiguates full from empty.
- out_data is a combinational pass-through; no data storage.

Optional Feature:
- Macro: ARB_RESP_ROUTER_CHECK_EN
- Defined:
  - err sets on the next posedge and stays set until rst when any of these occur:
    - req_fire while req_ready=0;
    - req_fire with req_grant not exactly one-hot (zero or multiple bits);
    - resp_valid while count=0.
  - Routing behaviour is otherwise identical.
- Undefined: err tied to 0; no checking logic is synthesised.

Test Plan:
- Reset, then 3 pushes with grants 4'b0010, 4'b1000, 4'b0001 and out_ready=4'b1111, then three responses resp_data=A,B,C -> out_valid sequence 4'b0010, 4'b1000, 4'b0001 with out_data A, B, C; outstanding goes 3, 2, 1, 0.
- Fill DEPTH=4 with grant 4'b0100 -> req_ready=0 after the 4th push; a 5th req_fire is not recorded (outstanding stays 4); one pop -> req_ready=1 next cycle.
- Head idx=2, resp_valid=1, out_ready=4'b1011 -> resp_ready=0 and out_valid=4'b0100 held for 3 cycles; set out_ready[2]=1 -> single pop, outstanding decrements by 1.
- Occupancy 2 with simultaneous push and pop every cycle for 10 cycles (grants rotating 1,2,4,8) -> outstanding constant at 2, pointers wrap, responses route in push order.
- Empty, resp_valid=1 -> resp_ready=0, out_valid=0; with ARB_RESP_ROUTER_CHECK_EN, err=1 next cycle and stays 1 until rst. Grant 4'b0110 on fire -> entry idx=1, err=1.
- rst asserted with outstanding=3 mid-response -> next cycle outstanding=0, out_valid=0, resp_ready=0, req_ready=1, err=0.
